// File: rtl/data_sram_confreg_responder_pkg.sv
// Shared constants and helpers for the data SRAM / config-register responder.
// Holds the region base, register offsets, reset values and the byte-merge rule.
package data_sram_confreg_responder_pkg;

   localparam logic [15:0] CONF_BASE_HI_DEF = 16'hBFAF;
   localparam int          CR_NUM           = 8;

   localparam logic [15:0] OFF_CR_BASE = 16'h8000;
   localparam logic [15:0] OFF_LED     = 16'hF000;
   localparam logic [15:0] OFF_NUM     = 16'hF004;
   localparam logic [15:0] OFF_SWITCH  = 16'hF008;
   localparam logic [15:0] OFF_TIMER   = 16'hF00C;

   localparam logic [31:0] CR_RST    = 32'h0;
   localparam logic [15:0] LED_RST   = 16'h0;
   localparam logic [31:0] NUM_RST   = 32'h0;
   localparam logic [31:0] TIMER_RST = 32'h0;
   localparam logic [7:0]  SW_RST    = 8'h0;
   localparam logic [31:0] RDATA_RST = 32'h0;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_CR,
      SEL_LED,
      SEL_NUM,
      SEL_SWITCH,
      SEL_TIMER
   } conf_sel_e;

   // Decode on the word offset (addr[15:2]); the byte offset never matters.
   function automatic conf_sel_e decode_conf(input logic [13:0] woff);
      conf_sel_e sel;
      sel = SEL_NONE;
      if (woff[13:3] == OFF_CR_BASE[15:5]) begin
         sel = SEL_CR;
      end else if (woff == OFF_LED[15:2]) begin
         sel = SEL_LED;
      end else if (woff == OFF_NUM[15:2]) begin
         sel = SEL_NUM;
      end else if (woff == OFF_SWITCH[15:2]) begin
         sel = SEL_SWITCH;
      end else if (woff == OFF_TIMER[15:2]) begin
         sel = SEL_TIMER;
      end
      return sel;
   endfunction

   function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  we);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_confreg_responder_if.sv
// Data SRAM request/response bundle between the core (master) and the responder (slave).
interface data_sram_confreg_responder_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output we, output addr, output wdata, input rdata);
   modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_confreg_responder_sram_1rw_be.sv
// Single-port byte-writable RAM; read returns the word as it was before this edge's write.
module sram_1rw_be #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         rdata_q <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_confreg_responder.sv
// Data SRAM responder: internal RAM plus memory-mapped config registers (CRs, LED, NUM,
// switches, free-running timer) with a registered one-cycle read path.
module data_sram_confreg_responder
   import data_sram_confreg_responder_pkg::*;
#(
   parameter int          RAM_AW       = 14,
   parameter logic [15:0] CONF_BASE_HI = CONF_BASE_HI_DEF
) (
   input  logic                               clk,
   input  logic                               resetn,
   data_sram_confreg_responder_if.slave       data_sram,
   output logic [15:0]                        led,
   output logic [31:0]                        num,
   input  logic [7:0]                         switch
);

   logic        is_conf;
   conf_sel_e   sel;
   logic [2:0]  cr_idx;
   logic        conf_wr;
   logic        ram_en;
   logic [31:0] conf_word;
   logic [31:0] ram_rdata;

   logic [31:0] cr_q [CR_NUM];
   logic [31:0] cr_d [CR_NUM];
   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  sw_meta_q, sw_meta_d;
   logic [7:0]  sw_sync_q, sw_sync_d;
   logic [31:0] conf_rdata_q, conf_rdata_d;
   logic        is_ram_q, is_ram_d;

   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^data_sram.addr[1:0];

   always_comb begin
      is_conf = (data_sram.addr[31:16] == CONF_BASE_HI);
      sel     = decode_conf(data_sram.addr[15:2]);
      cr_idx  = data_sram.addr[4:2];
      conf_wr = data_sram.en && is_conf && (data_sram.we != 4'h0);
      ram_en  = data_sram.en && !is_conf;

      conf_word = 32'h0;
      case (sel)
         SEL_CR:     conf_word = cr_q[cr_idx];
         SEL_LED:    conf_word = {16'h0, led_q};
         SEL_NUM:    conf_word = num_q;
         SEL_SWITCH: conf_word = {24'h0, sw_sync_q};
         SEL_TIMER:  conf_word = timer_q;
         default:    conf_word = 32'h0;
      endcase

      cr_d         = cr_q;
      led_d        = led_q;
      num_d        = num_q;
      timer_d      = timer_q + 32'd1;
      sw_meta_d    = switch;
      sw_sync_d    = sw_meta_q;
      conf_rdata_d = conf_rdata_q;
      is_ram_d     = is_ram_q;

      // The read side samples the pre-write value; RAM data arrives from the macro itself.
      if (data_sram.en) begin
         is_ram_d = !is_conf;
         if (is_conf) begin
            conf_rdata_d = conf_word;
         end
      end

      if (conf_wr) begin
         case (sel)
            SEL_CR:    cr_d[cr_idx] = merge_be(cr_q[cr_idx], data_sram.wdata, data_sram.we);
            SEL_LED:   led_d = {data_sram.we[1] ? data_sram.wdata[15:8] : led_q[15:8],
                                data_sram.we[0] ? data_sram.wdata[7:0]  : led_q[7:0]};
            SEL_NUM:   num_d = merge_be(num_q, data_sram.wdata, data_sram.we);
            SEL_TIMER: timer_d = merge_be(timer_q, data_sram.wdata, data_sram.we);
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cr_q         <= '{default: CR_RST};
         led_q        <= LED_RST;
         num_q        <= NUM_RST;
         timer_q      <= TIMER_RST;
         sw_meta_q    <= SW_RST;
         sw_sync_q    <= SW_RST;
         conf_rdata_q <= RDATA_RST;
         is_ram_q     <= 1'b0;
      end else begin
         cr_q         <= cr_d;
         led_q        <= led_d;
         num_q        <= num_d;
         timer_q      <= timer_d;
         sw_meta_q    <= sw_meta_d;
         sw_sync_q    <= sw_sync_d;
         conf_rdata_q <= conf_rdata_d;
         is_ram_q     <= is_ram_d;
      end
   end

   sram_1rw_be #(.AW(RAM_AW)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (data_sram.we),
      .addr  (data_sram.addr[RAM_AW+1:2]),
      .wdata (data_sram.wdata),
      .rdata (ram_rdata)
   );

   // is_ram_q clears on reset, so rdata reads 0 immediately without touching the RAM.
   assign data_sram.rdata = is_ram_q ? ram_rdata : conf_rdata_q;
   assign led             = led_q;
   assign num             = num_q;

endmodule
